// File: rtl/qr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// qr_ctrl_pkg
// Shared types and helpers for the QR-core buffer controllers.
//   seq_state_t    : sequencer state encoding
//   DEFAULT_N_COLS : default number of matrix columns / column buffers
//   MAX_COLS       : widest one-hot vector the onehot() helper can build
//   onehot()       : idx -> one-hot vector, all-zero when idx is outside [0, n)
// ---------------------------------------------------------------------------
package qr_ctrl_pkg;

    localparam int DEFAULT_N_COLS = 3;
    localparam int MAX_COLS       = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_GAP,
        READY,
        READ,
        READ_GAP
    } seq_state_t;

    // Callers size-cast the result down to their own column count.
    function automatic logic [MAX_COLS-1:0] onehot(input int idx, input int n);
        logic [MAX_COLS-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < MAX_COLS) begin
            v = {{(MAX_COLS-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/qr_seq_watchdog.sv
// ---------------------------------------------------------------------------
// qr_seq_watchdog
// Handshake watchdog for QR-core controllers. Counts cycles while enable is
// high; timeout is raised combinationally during the (2^WDOG_W-1)-th
// consecutive enabled cycle, so the controller can abort on that same edge.
// Ports:
//   clk     : clock
//   reset   : synchronous active-high reset
//   enable  : a guarded handshake is in progress this cycle
//   clear   : restart the count (controller is outside a guarded state)
//   timeout : limit reached this cycle
// ---------------------------------------------------------------------------
module qr_seq_watchdog #(
    parameter int WDOG_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic timeout
);

    // cnt_reg holds the number of enabled cycles already completed, so the
    // current cycle is number cnt_reg+1; the limit is hit when that equals
    // 2^WDOG_W-1.
    localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_W'((2 ** WDOG_W) - 2);

    logic [WDOG_W-1:0] cnt_reg;
    logic [WDOG_W-1:0] cnt_next;

    assign timeout = enable && !clear && (cnt_reg == LAST_CNT);

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (enable && !timeout) begin
            cnt_next = cnt_reg + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/qr_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// qr_buffer_sequencer
// Sequences a bank of N_COLS column buffers for the QR core: loads columns
// one after another, serves single-column read requests, tracks consumed
// columns and aborts any buffer handshake that stalls. No matrix data here.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   mat_start          : pulse, start loading a new matrix (IDLE only)
//   col_req / col_idx  : QR core column request (level) and column index
//   done_load          : per-buffer load-complete flags
//   done_read_vector   : per-buffer read-complete flags
//   start_write        : one-hot load strobe; also upstream write-select
//   start_read         : one-hot read strobe
//   busy, mat_loaded   : not IDLE / in READY
//   col_grant          : pulse, request accepted (with first start_read)
//   col_done           : pulse, granted column fully read
//   mat_consumed       : pulse, every column read once
//   err                : pulse, watchdog timeout or illegal request
// ---------------------------------------------------------------------------
module qr_buffer_sequencer
    import qr_ctrl_pkg::*;
#(
    parameter int N_COLS = DEFAULT_N_COLS,
    parameter int IDX_W  = $clog2(N_COLS),
    parameter int WDOG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mat_start,
    input  logic              col_req,
    input  logic [IDX_W-1:0]  col_idx,
    input  logic [N_COLS-1:0] done_load,
    input  logic [N_COLS-1:0] done_read_vector,
    output logic [N_COLS-1:0] start_write,
    output logic [N_COLS-1:0] start_read,
    output logic              busy,
    output logic              mat_loaded,
    output logic              col_grant,
    output logic              col_done,
    output logic              mat_consumed,
    output logic              err
);

    seq_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
    logic [IDX_W-1:0]  rd_idx_reg, rd_idx_next;
    logic [N_COLS-1:0] rd_mask_reg, rd_mask_next;

    logic [N_COLS-1:0] start_write_reg, start_write_next;
    logic [N_COLS-1:0] start_read_reg, start_read_next;
    logic              col_grant_reg, col_grant_next;
    logic              col_done_reg, col_done_next;
    logic              mat_consumed_reg, mat_consumed_next;
    logic              err_reg, err_next;

    // Transition events raised by the next-state logic.
    logic grant_evt, done_evt, err_evt;

    // ---------------------------------------------------------------
    // Per-column decode: done flags only count on the active buffer;
    // request index decoded once for the consumed-column lookup.
    // ---------------------------------------------------------------
    logic [N_COLS-1:0] load_hit;
    logic [N_COLS-1:0] read_hit;
    logic [N_COLS-1:0] req_sel;

    genvar gi;
    generate
        for (gi = 0; gi < N_COLS; gi++) begin : g_col
            assign load_hit[gi] = done_load[gi]        && (wr_idx_reg == IDX_W'(gi));
            assign read_hit[gi] = done_read_vector[gi] && (rd_idx_reg == IDX_W'(gi));
            assign req_sel[gi]  = (col_idx == IDX_W'(gi));
        end
    endgenerate

    logic load_done, read_done, req_in_range, req_legal;

    assign load_done    = |load_hit;
    assign read_done    = |read_hit;
    assign req_in_range = ({1'b0, col_idx} < (IDX_W+1)'(N_COLS));
    // A consumed column cannot be re-read: its buffer FIFO is already drained.
    assign req_legal    = req_in_range && ((rd_mask_reg & req_sel) == '0);

    // ---------------------------------------------------------------
    // Watchdog guards the LOAD and READ handshakes only.
    // ---------------------------------------------------------------
    logic wdog_enable, wdog_timeout;

    assign wdog_enable = (state_reg == LOAD) || (state_reg == READ);

    qr_seq_watchdog #(
        .WDOG_W (WDOG_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .enable  (wdog_enable),
        .clear   (!wdog_enable),
        .timeout (wdog_timeout)
    );

    // ---------------------------------------------------------------
    // State register (also holds indices, mask and registered outputs)
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            wr_idx_reg       <= '0;
            rd_idx_reg       <= '0;
            rd_mask_reg      <= '0;
            start_write_reg  <= '0;
            start_read_reg   <= '0;
            col_grant_reg    <= 1'b0;
            col_done_reg     <= 1'b0;
            mat_consumed_reg <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wr_idx_reg       <= wr_idx_next;
            rd_idx_reg       <= rd_idx_next;
            rd_mask_reg      <= rd_mask_next;
            start_write_reg  <= start_write_next;
            start_read_reg   <= start_read_next;
            col_grant_reg    <= col_grant_next;
            col_done_reg     <= col_done_next;
            mat_consumed_reg <= mat_consumed_next;
            err_reg          <= err_next;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic. Priority inside a state: watchdog, then the
    // active done flag, then a new request.
    // ---------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        wr_idx_next  = wr_idx_reg;
        rd_idx_next  = rd_idx_reg;
        rd_mask_next = rd_mask_reg;
        grant_evt    = 1'b0;
        done_evt     = 1'b0;
        err_evt      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (mat_start) begin
                    state_next  = LOAD;
                    wr_idx_next = '0;
                end
            end
            LOAD: begin
                if (wdog_timeout) begin
                    state_next   = IDLE;
                    rd_mask_next = '0;
                    err_evt      = 1'b1;
                end else if (load_done) begin
                    state_next = LOAD_GAP;
                end
            end
            LOAD_GAP: begin
                // One idle cycle lets the buffer see start_write low and re-arm.
                if (wr_idx_reg == IDX_W'(N_COLS - 1)) begin
                    state_next   = READY;
                    rd_mask_next = '0;
                end else begin
                    state_next  = LOAD;
                    wr_idx_next = wr_idx_reg + IDX_W'(1);
                end
            end
            READY: begin
                if (col_req) begin
                    if (req_legal) begin
                        state_next  = READ;
                        rd_idx_next = col_idx;
                        grant_evt   = 1'b1;
                    end else begin
                        err_evt = 1'b1;
                    end
                end
            end
            READ: begin
                if (wdog_timeout) begin
                    state_next   = IDLE;
                    rd_mask_next = '0;
                    err_evt      = 1'b1;
                end else if (read_done) begin
                    state_next   = READ_GAP;
                    rd_mask_next = rd_mask_reg | read_hit;
                    done_evt     = 1'b1;
                end
            end
            READ_GAP: begin
                // A request still held here is evaluated only once back in READY.
                if (&rd_mask_reg) begin
                    state_next   = IDLE;
                    rd_mask_next = '0;
                end else begin
                    state_next = READY;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic: next values of the registered outputs, so strobes
    // and pulses change on the same edge as the state they belong to.
    // ---------------------------------------------------------------
    always_comb begin
        start_write_next  = '0;
        start_read_next   = '0;
        col_grant_next    = grant_evt;
        col_done_next     = done_evt;
        // Reported alongside the col_done of the last column.
        mat_consumed_next = done_evt && (&rd_mask_next);
        err_next          = err_evt;

        if (state_next == LOAD) begin
            start_write_next = N_COLS'(onehot(int'(wr_idx_next), N_COLS));
        end
        if (state_next == READ) begin
            start_read_next = N_COLS'(onehot(int'(rd_idx_next), N_COLS));
        end
    end

    assign start_write  = start_write_reg;
    assign start_read   = start_read_reg;
    assign busy         = (state_reg != IDLE);
    assign mat_loaded   = (state_reg == READY);
    assign col_grant    = col_grant_reg;
    assign col_done     = col_done_reg;
    assign mat_consumed = mat_consumed_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_qr_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_qr_buffer_sequencer
// Directed and randomized stimulus for qr_buffer_sequencer. Expected outputs
// come from a cycle-level description of the intended behaviour: which
// column is being loaded/read, how long the buffer takes, and a set of
// columns already consumed in the current matrix.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qr_buffer_sequencer;

    localparam int N        = 3;
    localparam int IW       = 2;
    localparam int WW       = 4;
    localparam int WD_LIMIT = (2 ** WW) - 1;
    localparam logic [N-1:0] ALL = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          mat_start;
    logic          col_req;
    logic [IW-1:0] col_idx;
    logic [N-1:0]  done_load;
    logic [N-1:0]  done_read_vector;
    logic [N-1:0]  start_write;
    logic [N-1:0]  start_read;
    logic          busy, mat_loaded, col_grant, col_done, mat_consumed, err;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: columns read so far in the current matrix.
    logic [N-1:0] exp_mask;

    always #5 clk = ~clk;

    qr_buffer_sequencer #(
        .N_COLS (N),
        .IDX_W  (IW),
        .WDOG_W (WW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mat_start        (mat_start),
        .col_req          (col_req),
        .col_idx          (col_idx),
        .done_load        (done_load),
        .done_read_vector (done_read_vector),
        .start_write      (start_write),
        .start_read       (start_read),
        .busy             (busy),
        .mat_loaded       (mat_loaded),
        .col_grant        (col_grant),
        .col_done         (col_done),
        .mat_consumed     (mat_consumed),
        .err              (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs packed as {start_write, start_read, busy, mat_loaded,
    // col_grant, col_done, mat_consumed, err}.
    task automatic expect_outs(input string tag, input logic [N-1:0] sw, input logic [N-1:0] sr,
                               input logic b, input logic ml, input logic g,
                               input logic d, input logic c, input logic e);
        check(tag, {start_write, start_read, busy, mat_loaded, col_grant, col_done, mat_consumed, err},
                   {sw, sr, b, ml, g, d, c, e});
    endtask

    // Invariant: strobes one-hot or zero and never both active.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("strobe_invariant",
                  32'($onehot0(start_write) && $onehot0(start_read) &&
                      !((|start_write) && (|start_read))), 32'd1);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] rnd_others(input int active);
        logic [N-1:0] r;
        r = N'($urandom);
        return r & ~bit_of(active);
    endfunction

    function automatic int pick_bit(input logic [N-1:0] v);
        int cnt;
        int r;
        cnt = 0;
        for (int i = 0; i < N; i++) if (v[i]) cnt++;
        r = $urandom_range(0, cnt - 1);
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                if (r == 0) return i;
                r--;
            end
        end
        return 0;
    endfunction

    // Entered in cycle 0 of loading column c; leaves in the cycle after its gap.
    task automatic load_col(input int c, input int d, input bit noise);
        for (int k = 0; k < d; k++) begin
            expect_outs("load_strobe", bit_of(c), '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (noise) begin
                mat_start        = 1'($urandom_range(0, 1));
                done_load        = rnd_others(c);
                done_read_vector = N'($urandom);
            end
            if (k == d - 1) done_load = done_load | bit_of(c);
            tick();
        end
        mat_start        = 1'b0;
        done_load        = '0;
        done_read_vector = '0;
        expect_outs("load_gap", '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    // fixed_d = 0 picks a random buffer latency per column.
    task automatic load_matrix(input int fixed_d, input bit noise);
        int d;
        mat_start = 1'b1;
        tick();
        mat_start = 1'b0;
        for (int c = 0; c < N; c++) begin
            d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 10));
            load_col(c, d, noise);
        end
        expect_outs("loaded", '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_mask = '0;
        $display("[TB] load matrix fixed_d=%0d noise=%0d at %0t", fixed_d, noise, $time);
    endtask

    // Entered in a READY cycle. With hold, col_req stays high into READ_GAP
    // carrying next_idx, which must not be granted before the next READY cycle.
    task automatic read_col(input int idx, input int d, input bit hold, input int next_idx, input bit noise);
        bit consumed;
        col_req = 1'b1;
        col_idx = IW'(idx);
        tick();
        for (int k = 0; k < d; k++) begin
            expect_outs("read_strobe", '0, bit_of(idx), 1'b1, 1'b0, 1'(k == 0), 1'b0, 1'b0, 1'b0);
            if (noise) begin
                col_idx          = IW'($urandom_range(0, 3));
                mat_start        = 1'($urandom_range(0, 1));
                done_load        = N'($urandom);
                done_read_vector = rnd_others(idx);
            end
            if (k == d - 1) done_read_vector = done_read_vector | bit_of(idx);
            tick();
        end
        mat_start        = 1'b0;
        done_load        = '0;
        done_read_vector = '0;
        exp_mask         = exp_mask | bit_of(idx);
        consumed         = (exp_mask == ALL);
        expect_outs("read_gap", '0, '0, 1'b1, 1'b0, 1'b0, 1'b1, consumed, 1'b0);
        if (hold) begin
            col_req = 1'b1;
            col_idx = IW'(next_idx);
        end else begin
            col_req = 1'b0;
        end
        tick();
        if (consumed)
            expect_outs("after_consume", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        else
            expect_outs("back_ready", '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] read col %0d latency=%0d hold=%0d consumed=%0d", idx, d, hold, consumed);
    endtask

    task automatic illegal_req(input int idx);
        col_req = 1'b1;
        col_idx = IW'(idx);
        tick();
        col_req = 1'b0;
        expect_outs("illegal_err", '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_outs("illegal_after", '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] illegal request col %0d", idx);
    endtask

    // Entered in cycle 0 of a stalled handshake.
    task automatic expect_watchdog(input string tag, input logic [N-1:0] sw, input logic [N-1:0] sr,
                                   input bit granted);
        for (int k = 0; k < WD_LIMIT; k++) begin
            expect_outs(tag, sw, sr, 1'b1, 1'b0, 1'(granted && k == 0), 1'b0, 1'b0, 1'b0);
            tick();
        end
        expect_outs("wdog_fire", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_outs("wdog_idle", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] watchdog %s", tag);
    endtask

    initial begin
        int idx, nxt, forced, attempts;
        logic [N-1:0] rem;
        bit hold;

        reset            = 1'b1;
        mat_start        = 1'b0;
        col_req          = 1'b0;
        col_idx          = '0;
        done_load        = '0;
        done_read_vector = '0;
        exp_mask         = '0;
        repeat (3) tick();
        expect_outs("reset", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_outs("idle", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Nominal load (4-cycle buffer), out-of-order reads 2, 0, 1.
        load_matrix(4, 1'b0);
        read_col(2, 3, 1'b0, 0, 1'b0);
        read_col(0, 3, 1'b0, 0, 1'b0);
        read_col(1, 3, 1'b0, 0, 1'b0);

        // Illegal requests: out-of-range index, re-read of a consumed column.
        load_matrix(0, 1'b0);
        illegal_req(3);
        read_col(1, 2, 1'b0, 0, 1'b0);
        illegal_req(1);
        read_col(0, 2, 1'b0, 0, 1'b0);
        read_col(2, 2, 1'b0, 0, 1'b0);

        // Ignored mat_start during load, requests held through READ_GAP.
        load_matrix(0, 1'b1);
        read_col(0, 2, 1'b1, 2, 1'b0);
        read_col(2, 5, 1'b1, 1, 1'b0);
        read_col(1, 1, 1'b0, 0, 1'b0);

        // Watchdog on a stalled load of column 1.
        mat_start = 1'b1;
        tick();
        mat_start = 1'b0;
        load_col(0, 4, 1'b0);
        expect_watchdog("wdog_load", 3'b010, '0, 1'b0);

        // Watchdog on a stalled read of column 0.
        load_matrix(0, 1'b0);
        col_req = 1'b1;
        col_idx = 2'd0;
        tick();
        col_req = 1'b0;
        expect_watchdog("wdog_read", '0, 3'b001, 1'b1);

        // Reset in the middle of reading column 1, then a clean matrix.
        load_matrix(0, 1'b0);
        col_req = 1'b1;
        col_idx = 2'd1;
        tick();
        expect_outs("pre_reset_read", '0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_outs("pre_reset_read2", '0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset   = 1'b1;
        col_req = 1'b0;
        tick();
        expect_outs("mid_reset", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_outs("post_reset", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        load_matrix(0, 1'b0);
        read_col(1, 3, 1'b0, 0, 1'b0);
        read_col(0, 3, 1'b0, 0, 1'b0);
        read_col(2, 3, 1'b0, 0, 1'b0);

        // Randomized matrices with random request orders and latencies.
        for (int m = 0; m < 12; m++) begin
            load_matrix(0, 1'b1);
            forced   = -1;
            attempts = 0;
            while (exp_mask != ALL) begin
                attempts++;
                if (forced >= 0) idx = forced;
                else if (attempts > 10) idx = pick_bit(ALL & ~exp_mask);
                else idx = int'($urandom_range(0, 3));
                forced = -1;
                if (idx >= N || exp_mask[idx]) begin
                    illegal_req(idx);
                end else begin
                    rem  = ALL & ~(exp_mask | bit_of(idx));
                    hold = (rem != '0) && ($urandom_range(0, 1) == 1);
                    nxt  = hold ? pick_bit(rem) : 0;
                    read_col(idx, int'($urandom_range(1, 10)), hold, nxt, 1'b1);
                    if (hold) forced = nxt;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
